prt_vtb_cke_gen: RTL and testbench
==================================

# prt_vtb_cke_gen

Video toolbox clock-enable generator: from the system clock, it produces a clock-enable pulse train whose average rate equals a programmed frequency in Hz. It is the stimulus counterpart of the toolbox frequency counter. Its CKE_OUT drives the counter's monitored clock-enable, or any toolbox datapath that needs a paced enable. Pacing uses an exact Bresenham/NCO accumulator, so over any P_SYS_FREQ consecutive cycles of a run, exactly FREQ pulses are emitted. It optionally stops after a programmed pulse count.

## Interface
- P_SYS_FREQ, default 125000000: system clock frequency in Hz; the accumulator modulus. Must be ≥ 1 and < 2^32.
- SYS_CLK_IN  in  1  system clock; the only clock.
- SYS_RST_IN  in  1  reset, asynchronous, active-low.
- CTL_START_IN  in  1  one-cycle strobe; starts a run from idle.
- CTL_STOP_IN  in  1  one-cycle strobe; aborts a run.
- CTL_FREQ_IN  in  32  target pulse rate in Hz; sampled on an accepted start.
- CTL_CNT_IN  in  32  number of pulses to emit; 0 = continuous. Sampled on an accepted start.
- CKE_OUT  out  1  registered clock-enable pulse.
- STA_BUSY_OUT  out  1  high while in sm_run.
- STA_DONE_OUT  out  1  one-cycle pulse when the programmed count completes.
- STA_ERR_OUT  out  1  sticky; the sampled frequency exceeded P_SYS_FREQ and was clamped.
- STA_PULSES_OUT  out  32  pulses emitted since the last accepted start; wraps modulo 2^32.

## Operation
- **States:** sm_idle and sm_run.
- **sm_idle → sm_run:** on CTL_START_IN=1 and CTL_STOP_IN=0. At that edge the block:
  - latches freq = min(CTL_FREQ_IN, P_SYS_FREQ) and cnt = CTL_CNT_IN;
  - sets STA_ERR_OUT = (CTL_FREQ_IN > P_SYS_FREQ);
  - clears acc and STA_PULSES_OUT to 0.
- **sm_run, each edge:**
  - sum = acc + freq, using a 33-bit adder.
  - If sum ≥ P_SYS_FREQ, then acc ← sum − P_SYS_FREQ and CKE_OUT ← 1. Otherwise acc ← sum and CKE_OUT ← 0.
  - Because acc < P_SYS_FREQ and freq ≤ P_SYS_FREQ, one subtraction always suffices.
- **Pulse counting:** each emitted pulse increments STA_PULSES_OUT. When cnt ≠ 0 and the pulse being emitted is pulse number cnt, at that same edge:
  - state ← sm_idle;
  - STA_DONE_OUT ← 1 for one cycle, coincident with the final CKE_OUT cycle.
- **sm_run → sm_idle on CTL_STOP_IN:** CTL_STOP_IN has priority over pulse generation. At that edge CKE_OUT ← 0, no pulse is counted and STA_DONE_OUT stays 0.
- **sm_idle outputs:** CKE_OUT = 0 and acc is held. STA_PULSES_OUT and STA_ERR_OUT keep their values until the next accepted start.
- **Ignored or blocked inputs:**
  - CTL_START_IN in sm_run is ignored; there is no restart and no re-latch of freq/cnt.
  - CTL_START_IN and CTL_STOP_IN together in sm_idle: the start is not accepted.
- **freq = 0:** no pulses are emitted. With cnt ≠ 0 the run never completes; the block stays busy until CTL_STOP_IN.
- **Reset (SYS_RST_IN=0, asynchronous, including mid-run):**
  - state = sm_idle;
  - CKE_OUT, STA_BUSY_OUT, STA_DONE_OUT, STA_ERR_OUT = 0;
  - STA_PULSES_OUT, acc, freq, cnt = 0.

## Timing
- The start is accepted at edge 0. The pulse decision for run cycle k (edge k ≥ 1) is CKE_OUT=1 iff floor(k·freq/P) > floor((k−1)·freq/P).
- The first pulse appears at edge ceil(P/freq). With freq=P, CKE_OUT is high from edge 1 continuously.
- STA_BUSY_OUT rises at edge 0 and falls at the completion/stop edge.
- STA_DONE_OUT and the final CKE_OUT are the same cycle. CKE_OUT is 0 in the following cycle.
- STA_PULSES_OUT updates at the same edge as the CKE_OUT it counts.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The 33-bit add, compare and subtract path closes in one cycle at P_SYS_FREQ.

## Test plan
- **Integer divide:** P_SYS_FREQ=100, FREQ=25, CNT=0, start → CKE_OUT high at edges 4, 8, 12…; exactly 25 pulses in edges 1–100; BUSY stays 1.
- **Fractional rate:** P_SYS_FREQ=100, FREQ=37, CNT=10 → pulse spacing is only 2 or 3 cycles; the 10th pulse is at edge 28 with DONE=1 that cycle; BUSY falls at that edge; PULSES=10; CKE_OUT=0 at edge 29.
- **Full rate and clamp:** FREQ=100 → CKE_OUT constant 1 from edge 1, ERR=0. Restart with FREQ=150 → CKE_OUT constant 1, ERR=1. Next start with FREQ=50 → ERR=0.
- **Stop, start-ignore and collision:**
  - FREQ=50, CNT=0; CTL_STOP_IN on a cycle where a pulse is due → CKE_OUT=0 next cycle, PULSES not incremented, DONE=0.
  - CTL_START_IN during the run → no effect.
  - START+STOP together in idle → stays idle.
- **Zero frequency and reset:**
  - FREQ=0, CNT=5 → no pulses and BUSY=1 for over 1000 cycles; STOP returns the block to idle.
  - Assert SYS_RST_IN=0 mid-run, asynchronous to SYS_CLK_IN → all outputs 0 immediately.
- **Loopback:** CKE_OUT drives the frequency counter's MON_CKE_IN, with both blocks using P_SYS_FREQ=10000 and FREQ=1234 → the counter reports 1234 (within ±1 at gate edges).

Source files
------------

// File: rtl/prt_vtb_cke_gen_if.sv
// Control/status bundle of the clock-enable generator.
// The slave modport is the generator side; the master modport is the controller side.
interface prt_vtb_cke_gen_if;
  logic        CTL_START_IN;
  logic        CTL_STOP_IN;
  logic [31:0] CTL_FREQ_IN;
  logic [31:0] CTL_CNT_IN;
  logic        CKE_OUT;
  logic        STA_BUSY_OUT;
  logic        STA_DONE_OUT;
  logic        STA_ERR_OUT;
  logic [31:0] STA_PULSES_OUT;

  modport slave (
    input  CTL_START_IN, CTL_STOP_IN, CTL_FREQ_IN, CTL_CNT_IN,
    output CKE_OUT, STA_BUSY_OUT, STA_DONE_OUT, STA_ERR_OUT, STA_PULSES_OUT
  );

  modport master (
    output CTL_START_IN, CTL_STOP_IN, CTL_FREQ_IN, CTL_CNT_IN,
    input  CKE_OUT, STA_BUSY_OUT, STA_DONE_OUT, STA_ERR_OUT, STA_PULSES_OUT
  );
endinterface

// File: rtl/prt_vtb_cke_gen.sv
// Paced clock-enable generator: an NCO accumulator with modulus P_SYS_FREQ emits
// exactly FREQ pulses per P_SYS_FREQ cycles, optionally stopping after CNT pulses.
//
// state   | meaning
// SM_IDLE | waiting for an accepted start; acc held, CKE_OUT low
// SM_RUN  | accumulating freq each cycle, emitting CKE_OUT on wrap
module prt_vtb_cke_gen #(
  parameter logic [31:0] P_SYS_FREQ = 32'd125000000
) (
  input logic              SYS_CLK_IN,
  input logic              SYS_RST_IN,
  prt_vtb_cke_gen_if.slave bus
);

  localparam logic [0:0] SM_IDLE = 1'b0;
  localparam logic [0:0] SM_RUN  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] freq_q, freq_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pulses_q, pulses_d;
  logic        cke_q, cke_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [32:0] sum;
  logic        wrap;
  logic [31:0] pulses_inc;
  logic        start_ok;

  assign sum        = {1'b0, acc_q} + {1'b0, freq_q};
  assign wrap       = (sum >= {1'b0, P_SYS_FREQ});
  assign pulses_inc = pulses_q + 32'd1;
  assign start_ok   = bus.CTL_START_IN && !bus.CTL_STOP_IN;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    freq_d   = freq_q;
    cnt_d    = cnt_q;
    pulses_d = pulses_q;
    err_d    = err_q;
    cke_d    = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      SM_IDLE: begin
        if (start_ok) begin
          state_d  = SM_RUN;
          // Over-range requests are clamped to full rate and flagged.
          freq_d   = (bus.CTL_FREQ_IN > P_SYS_FREQ) ? P_SYS_FREQ : bus.CTL_FREQ_IN;
          cnt_d    = bus.CTL_CNT_IN;
          err_d    = (bus.CTL_FREQ_IN > P_SYS_FREQ);
          acc_d    = 32'd0;
          pulses_d = 32'd0;
        end
      end
      SM_RUN: begin
        if (bus.CTL_STOP_IN) begin
          state_d = SM_IDLE;
        end else begin
          // acc < P and freq <= P, so a single subtraction keeps acc in range.
          acc_d = wrap ? (sum[31:0] - P_SYS_FREQ) : sum[31:0];
          cke_d = wrap;
          if (wrap) begin
            pulses_d = pulses_inc;
            if ((cnt_q != 32'd0) && (pulses_inc == cnt_q)) begin
              state_d = SM_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = SM_IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK_IN or negedge SYS_RST_IN) begin
    if (!SYS_RST_IN) begin
      state_q  <= SM_IDLE;
      acc_q    <= 32'd0;
      freq_q   <= 32'd0;
      cnt_q    <= 32'd0;
      pulses_q <= 32'd0;
      cke_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      freq_q   <= freq_d;
      cnt_q    <= cnt_d;
      pulses_q <= pulses_d;
      cke_q    <= cke_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.CKE_OUT        = cke_q;
  assign bus.STA_BUSY_OUT   = (state_q == SM_RUN);
  assign bus.STA_DONE_OUT   = done_q;
  assign bus.STA_ERR_OUT    = err_q;
  assign bus.STA_PULSES_OUT = pulses_q;

endmodule

// File: tb/tb_prt_vtb_cke_gen.sv
// Directed bench for prt_vtb_cke_gen: a vector table of runs plus hand sequences
// for stop collision, ignored starts, async reset and a long-modulus loopback run.
module tb_prt_vtb_cke_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prt_vtb_cke_gen_if bus ();
  prt_vtb_cke_gen_if lb ();

  prt_vtb_cke_gen #(.P_SYS_FREQ(32'd100)) dut (
    .SYS_CLK_IN(clk), .SYS_RST_IN(rst_n), .bus(bus.slave)
  );
  prt_vtb_cke_gen #(.P_SYS_FREQ(32'd10000)) dut_lb (
    .SYS_CLK_IN(clk), .SYS_RST_IN(rst_n), .bus(lb.slave)
  );

  typedef struct {
    logic [31:0] freq;
    logic [31:0] cnt;
    int          n;
    int          exp_pulses;
    int          exp_first;
    int          exp_done_edge;
    logic        exp_busy;
    logic        exp_err;
  } vec_t;

  vec_t vecs[9];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] f, input logic [31:0] c);
    bus.CTL_FREQ_IN  = f;
    bus.CTL_CNT_IN   = c;
    bus.CTL_START_IN = 1'b1;
    step();
    bus.CTL_START_IN = 1'b0;
  endtask

  task automatic do_stop();
    bus.CTL_STOP_IN = 1'b1;
    step();
    bus.CTL_STOP_IN = 1'b0;
  endtask

  initial begin
    int seen, first, dones, done_edge;
    bus.CTL_START_IN = 1'b0;
    bus.CTL_STOP_IN  = 1'b0;
    bus.CTL_FREQ_IN  = 32'd0;
    bus.CTL_CNT_IN   = 32'd0;
    lb.CTL_START_IN  = 1'b0;
    lb.CTL_STOP_IN   = 1'b0;
    lb.CTL_FREQ_IN   = 32'd0;
    lb.CTL_CNT_IN    = 32'd0;

    //            freq    cnt    n     pulses first done  busy  err
    vecs[0] = '{32'd25,  32'd0,  100,  25,    4,    0,    1'b1, 1'b0};
    vecs[1] = '{32'd37,  32'd0,  100,  37,    3,    0,    1'b1, 1'b0};
    vecs[2] = '{32'd100, 32'd0,  50,   50,    1,    0,    1'b1, 1'b0};
    vecs[3] = '{32'd150, 32'd0,  50,   50,    1,    0,    1'b1, 1'b1};
    vecs[4] = '{32'd50,  32'd0,  40,   20,    2,    0,    1'b1, 1'b0};
    vecs[5] = '{32'd1,   32'd0,  250,  2,     100,  0,    1'b1, 1'b0};
    vecs[6] = '{32'd37,  32'd10, 40,   10,    3,    28,   1'b0, 1'b0};
    vecs[7] = '{32'd99,  32'd3,  10,   3,     2,    4,    1'b0, 1'b0};
    vecs[8] = '{32'd0,   32'd5,  1100, 0,     0,    0,    1'b1, 1'b0};

    #13;
    check("rst_cke", {31'd0, bus.CKE_OUT}, 32'd0);
    check("rst_busy", {31'd0, bus.STA_BUSY_OUT}, 32'd0);
    check("rst_pulses", bus.STA_PULSES_OUT, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      do_start(vecs[i].freq, vecs[i].cnt);
      seen = 0; first = 0; dones = 0; done_edge = 0;
      for (int k = 1; k <= vecs[i].n; k++) begin
        step();
        if (bus.CKE_OUT) begin
          seen++;
          if (first == 0) first = k;
        end
        if (bus.STA_DONE_OUT) begin
          dones++;
          done_edge = k;
        end
      end
      check($sformatf("v%0d_cke_count", i), seen, vecs[i].exp_pulses);
      check($sformatf("v%0d_pulses", i), bus.STA_PULSES_OUT, vecs[i].exp_pulses);
      check($sformatf("v%0d_first", i), first, vecs[i].exp_first);
      check($sformatf("v%0d_done_edge", i), done_edge, vecs[i].exp_done_edge);
      check($sformatf("v%0d_done_count", i), dones, (vecs[i].exp_done_edge != 0) ? 1 : 0);
      check($sformatf("v%0d_busy", i), {31'd0, bus.STA_BUSY_OUT}, {31'd0, vecs[i].exp_busy});
      check($sformatf("v%0d_err", i), {31'd0, bus.STA_ERR_OUT}, {31'd0, vecs[i].exp_err});
      do_stop();
      check($sformatf("v%0d_stopped", i), {31'd0, bus.STA_BUSY_OUT}, 32'd0);
    end

    // Stop lands on an edge where a pulse is due (freq=50 pulses on even edges).
    do_start(32'd50, 32'd0);
    repeat (3) step();
    check("coll_pre_pulses", bus.STA_PULSES_OUT, 32'd1);
    do_stop();
    check("coll_cke", {31'd0, bus.CKE_OUT}, 32'd0);
    check("coll_pulses", bus.STA_PULSES_OUT, 32'd1);
    check("coll_done", {31'd0, bus.STA_DONE_OUT}, 32'd0);
    check("coll_busy", {31'd0, bus.STA_BUSY_OUT}, 32'd0);

    // Start during a run must neither restart nor re-latch freq/cnt.
    do_start(32'd25, 32'd0);
    repeat (10) step();
    bus.CTL_FREQ_IN  = 32'd100;
    bus.CTL_CNT_IN   = 32'd1;
    bus.CTL_START_IN = 1'b1;
    step();
    bus.CTL_START_IN = 1'b0;
    repeat (9) step();
    check("ign_pulses", bus.STA_PULSES_OUT, 32'd5);
    check("ign_busy", {31'd0, bus.STA_BUSY_OUT}, 32'd1);
    do_stop();

    // Start and stop together in idle: start refused, status held.
    bus.CTL_FREQ_IN  = 32'd100;
    bus.CTL_START_IN = 1'b1;
    bus.CTL_STOP_IN  = 1'b1;
    step();
    bus.CTL_START_IN = 1'b0;
    bus.CTL_STOP_IN  = 1'b0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.CKE_OUT) seen++;
    end
    check("both_busy", {31'd0, bus.STA_BUSY_OUT}, 32'd0);
    check("both_cke_count", seen, 0);
    check("both_pulses_held", bus.STA_PULSES_OUT, 32'd5);

    // Error flag is sticky in idle and cleared by the next in-range start.
    do_start(32'd150, 32'd0);
    step();
    do_stop();
    check("err_sticky", {31'd0, bus.STA_ERR_OUT}, 32'd1);
    do_start(32'd50, 32'd0);
    check("err_cleared", {31'd0, bus.STA_ERR_OUT}, 32'd0);
    do_stop();

    // Asynchronous reset mid-run, between clock edges.
    do_start(32'd150, 32'd0);
    repeat (5) step();
    check("ar_pre_cke", {31'd0, bus.CKE_OUT}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_cke", {31'd0, bus.CKE_OUT}, 32'd0);
    check("ar_busy", {31'd0, bus.STA_BUSY_OUT}, 32'd0);
    check("ar_done", {31'd0, bus.STA_DONE_OUT}, 32'd0);
    check("ar_err", {31'd0, bus.STA_ERR_OUT}, 32'd0);
    check("ar_pulses", bus.STA_PULSES_OUT, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Long modulus: exactly 1234 pulses over 10000 cycles.
    lb.CTL_FREQ_IN  = 32'd1234;
    lb.CTL_CNT_IN   = 32'd0;
    lb.CTL_START_IN = 1'b1;
    step();
    lb.CTL_START_IN = 1'b0;
    repeat (10000) step();
    check("lb_pulses", lb.STA_PULSES_OUT, 32'd1234);
    check("lb_busy", {31'd0, lb.STA_BUSY_OUT}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
